// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding and port indices.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_CORE   = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_lock_arbiter.sv
// Combinational round-robin decision between the core (port 0) and the
// loader (port 1), with a lock that lets the loader keep ownership.
module rr_lock_arbiter
  import data_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic lock1,
  input  logic last_owner,
  output logic winner,
  output logic valid
);

  // Single requester wins outright; on contention the loader keeps the port
  // while it holds lock1, otherwise ownership flips away from last_owner.
  always_comb begin
    winner = PORT_CORE;
    valid  = req0 | req1;
    if (req1 && lock1 && (last_owner == PORT_LOADER)) begin
      winner = PORT_LOADER;
    end else if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = PORT_LOADER;
    end else begin
      winner = PORT_CORE;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter and IDLE/ACCESS/RESP sequencer for the shared
// big-endian, byte-addressed data memory port.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int MEM_DEPTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0,
  input  logic                      req1,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [ADDR_BUS_WIDTH-1:0] addr0,
  input  logic [ADDR_BUS_WIDTH-1:0] addr1,
  input  logic [DATA_BUS_WIDTH-1:0] wdata0,
  input  logic [DATA_BUS_WIDTH-1:0] wdata1,
  input  logic                      lock1,
  output logic                      gnt0,
  output logic                      gnt1,
  output logic                      ack0,
  output logic                      ack1,
  output logic [DATA_BUS_WIDTH-1:0] rdata,
  output logic                      err,
  output logic                      busy,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  output logic                      mem_write_en,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata
);

  // Highest byte address at which a full 4-byte word still fits.
  localparam logic [ADDR_BUS_WIDTH-1:0] LAST_WORD_ADDR = ADDR_BUS_WIDTH'(MEM_DEPTH - 4);

  // Full-width compare so high address bits can never alias into range.
  function automatic logic out_of_range(input logic [ADDR_BUS_WIDTH-1:0] a);
    return a > LAST_WORD_ADDR;
  endfunction

  state_t                    state, state_nxt;
  logic                      last_owner;
  logic                      arb_win, arb_vld, start;
  logic                      owner_p1, we_p1, range_err_p1;
  logic [ADDR_BUS_WIDTH-1:0] addr_p1, sel_addr;
  logic [DATA_BUS_WIDTH-1:0] wdata_p1, sel_wdata;
  logic                      sel_we;

  rr_lock_arbiter u_arb (
    .req0       (req0),
    .req1       (req1),
    .lock1      (lock1),
    .last_owner (last_owner),
    .winner     (arb_win),
    .valid      (arb_vld)
  );

  assign start     = (state == ST_IDLE) && arb_vld;
  assign sel_addr  = (arb_win == PORT_LOADER) ? addr1  : addr0;
  assign sel_wdata = (arb_win == PORT_LOADER) ? wdata1 : wdata0;
  assign sel_we    = (arb_win == PORT_LOADER) ? we1    : we0;

  // The memory port follows the latches, so it holds between accesses.
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and decoded outputs; strobes depend only on state and latches.
  always_comb begin
    state_nxt    = state;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    mem_write_en = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (arb_vld) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_nxt    = ST_RESP;
        gnt0         = (owner_p1 == PORT_CORE);
        gnt1         = (owner_p1 == PORT_LOADER);
        mem_write_en = we_p1 & ~range_err_p1;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        ack0      = (owner_p1 == PORT_CORE);
        ack1      = (owner_p1 == PORT_LOADER);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // IDLE -> ACCESS boundary: capture the winner's request and range check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner   <= PORT_LOADER;
      owner_p1     <= PORT_CORE;
      we_p1        <= 1'b0;
      addr_p1      <= '0;
      wdata_p1     <= '0;
      range_err_p1 <= 1'b0;
    end else if (start) begin
      last_owner   <= arb_win;
      owner_p1     <= arb_win;
      we_p1        <= sel_we;
      addr_p1      <= sel_addr;
      wdata_p1     <= sel_wdata;
      range_err_p1 <= out_of_range(sel_addr);
    end
  end

  // ACCESS -> RESP boundary: register read data and error for the ack cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (state == ST_ACCESS) begin
      rdata <= (range_err_p1 || we_p1) ? '0 : mem_rdata;
      err   <= range_err_p1;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and access sequencer for the byte-addressed, big-endian 4-byte-word data memory. It shares the single memory port between the core load/store path (port 0) and the program/debug loader (port 1). Each access runs through a fixed IDLE→ACCESS→RESP sequence and is arbitrated round-robin, with an optional lock that lets port 1 hold ownership for bursts. Out-of-range accesses are range-checked and blocked.

## Interface
- ADDR_BUS_WIDTH, 32, address width of requesters and memory port
- DATA_BUS_WIDTH, 32, data width (four bytes)
- MEM_DEPTH, 64, memory size in bytes; must equal the data memory depth
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_BUS_WIDTH  byte address of word MSB
- wdata0 / wdata1  in  DATA_BUS_WIDTH  write data
- lock1  in  1  port 1 keeps ownership while high
- gnt0 / gnt1  out  1  high during ACCESS for the owning port
- ack0 / ack1  out  1  one-cycle pulse in RESP for the owning port
- rdata  out  DATA_BUS_WIDTH  registered read data, valid with ack
- err  out  1  registered range error, valid with ack
- busy  out  1  high when state is not IDLE
- mem_addr  out  ADDR_BUS_WIDTH  to data memory addr
- mem_wdata  out  DATA_BUS_WIDTH  to data memory write_data
- mem_write_en  out  1  to data memory write_en
- mem_rdata  in  DATA_BUS_WIDTH  from data memory read_data (combinational)

## Operation
- FSM states: IDLE, ACCESS, RESP. Transitions: IDLE→ACCESS when any req is high; ACCESS→RESP always; RESP→IDLE always.
- Arbitration happens in IDLE only. It uses the last_owner register, whose reset value is 1.
  - Only one req high: that port wins.
  - Both high: the port other than last_owner wins.
  - Exception: last_owner=1 and lock1=1 and req1=1 gives port 1 the grant regardless.
- On the IDLE→ACCESS edge:
  - owner, we, addr and wdata of the winner are latched.
  - last_owner is updated.
  - range_err = (addr > MEM_DEPTH-4) is latched, computed at full ADDR_BUS_WIDTH with no truncation.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latches.
  - mem_write_en = we & ~range_err.
  - gnt of the owner is high.
  - rdata is captured from mem_rdata at the end of the cycle (0 if range_err or write).
- RESP: ack of the owner is high, err = range_err.
- Requests are sampled only in IDLE. Changes to a requester's inputs after it is granted are ignored. A req still high in the IDLE cycle after ack counts as a new request.
- Outside ACCESS, mem_write_en is 0 and mem_addr / mem_wdata hold their last value.

## Timing
- Latency: req sampled at edge N → gnt in cycle N+1 → ack/rdata/err in cycle N+2.
- Maximum throughput is one access per 3 cycles.
- The memory write commits on the ACCESS→RESP edge. A read issued immediately afterwards sees the new data.
- mem_write_en is decoded from state and the latches, so it is glitch-free with respect to requester inputs.
- Reset values: state=IDLE, last_owner=1, all gnt/ack=0, rdata=0, err=0, busy=0, mem_addr=0, mem_wdata=0, mem_write_en=0.
- Reset asserted mid-operation: all outputs go to reset values immediately and asynchronously, and no ack is issued. A write coinciding with reset assertion is not guaranteed to commit. Memory contents are not cleared.
- Simultaneous req0 and req1 with no lock alternate strictly: 0, 1, 0, 1.

## Structure
- Shared package holds the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the port index constants (PORT_CORE=0, PORT_LOADER=1).
- The round-robin/lock decision goes in a sub-module, rr_lock_arbiter (combinational: req0, req1, lock1, last_owner → winner, valid).
- The top instantiates it next to the FSM, the latches and the range check. The data memory is instantiated by the parent, not inside this block.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 8, then reads addr 8:
  - the write gives ack0 at cycle +2 with err=0;
  - the read returns rdata=0xDEADBEEF;
  - a read at addr 9 returns 0xADBEEFxx.
- req0 and req1 both held high for 4 accesses: grant order 0, 1, 0, 1; every access takes exactly 3 cycles; acks never overlap.
- lock1 high while both request: port 1 is granted 3 times in a row; lock1 dropped → next grant goes to port 0.
- Port 1 writes to addr 61 (MEM_DEPTH-3): mem_write_en stays 0, ack1 with err=1, bytes 60–63 unchanged. Addr 60 succeeds with err=0.
- rst asserted during ACCESS of a write: mem_write_en, gnt and busy drop in the same cycle, no ack follows, state=IDLE. The next req0 is granted normally.
- Requester changes addr0 and wdata0 during ACCESS: the memory sees the latched values; the ack reflects the original access.
